wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage sitting directly upstream of the register file write port. It merges single-cycle ALU results with long-latency load/multicycle results, which are buffered in a small in-order FIFO, and drives one registered write (reg_write/rd/write_data) per cycle into the register file. It exports a busy mask of destination registers with writes still pending, which decode uses for hazard stalls.

Parameters:
DATA_W, 32, result/register data width
ADDR_W, 5, register index width (32 registers)
DEPTH, 2, long-latency result buffer entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive cycles buffered results may lose to the ALU before the ALU is blocked for one cycle

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result valid this cycle
alu_ready  output  1  stage accepts the ALU result this cycle
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
lsu_valid  input  1  long-latency result valid
lsu_ready  output  1  buffer has space
lsu_rd  input  ADDR_W  long-latency destination register
lsu_data  input  DATA_W  long-latency result
reg_write  output  1  register file write enable (registered)
rd  output  ADDR_W  register file write index (registered)
write_data  output  DATA_W  register file write data (registered)
busy_mask  output  2**ADDR_W  bit i set = write to register i still pending

Behaviour:
- Reset (rst_n low, async): reg_write=0, rd=0, write_data=0, FIFO count=0, pointers=0, starve_cnt=0. Hence busy_mask=0, lsu_ready=1, alu_ready=1. Reset mid-operation discards all buffered results.
- Handshakes: alu_fire = alu_valid & alu_ready; push = lsu_valid & lsu_ready. Inputs must stay stable while valid & !ready.
- lsu_ready = (count != DEPTH), from registered count only; no combinational dependency on lsu_valid or on the same-cycle pop.
- alu_ready = (starve_cnt != STARVE_LIMIT).
- Arbitration, per cycle: if alu_fire, the ALU result is selected. Otherwise, if count != 0, the FIFO head is popped (drain). Otherwise nothing is selected.
- Output register, next edge:
  - reg_write <= alu_fire | drain.
  - rd/write_data <= the selected source.
  - If nothing is selected, reg_write <= 0 and rd/write_data hold their previous values.
- Latency:
  - ALU result accepted at edge k: reg_write is high in cycle k..k+1, and the register file commits at edge k+1.
  - LSU result pushed at edge k: earliest commit is at edge k+2. LSU results never bypass the FIFO.
- FIFO:
  - Strict in-order.
  - Push and pop in the same cycle are legal at any count, including full. When full, lsu_ready is already 0, so no push occurs.
  - Pointers wrap modulo DEPTH.
- Starvation:
  - starve_cnt increments (saturating at STARVE_LIMIT) in each cycle with count!=0 & alu_fire.
  - It clears to 0 in any cycle with drain or count==0.
  - At STARVE_LIMIT, alu_ready=0 for exactly that cycle, the head drains, and the counter clears.
- busy_mask = OR of one-hot(rd) over all valid FIFO entries, OR one-hot(rd) if reg_write=1. It is combinational from registered state.
- Duplicate rd values in the FIFO are legal; the later entry commits last. Ordering between ALU and LSU writes to the same rd is not enforced here; decode must stall on busy_mask.
- Writes to register 0 are passed through unchanged.

Test Plan:
- Reset then idle: rst_n low mid-stream with 2 entries buffered -> reg_write=0, busy_mask=0, lsu_ready=1 immediately, with no write after release.
- ALU only: alu_valid=1, rd=3, data=0xDEADBEEF at edge k -> reg_write=1, rd=3, write_data=0xDEADBEEF in cycle after k; reg_write=0 the next cycle if no new input.
- LSU only: push rd=7, data=0x12345678 at edge k -> busy_mask[7]=1 after k, write visible after edge k+1, busy_mask[7]=0 after edge k+2.
- Fill/backpressure: push 2 LSU results with ALU continuously valid -> lsu_ready=0 after second push; a third lsu_valid is held off until the first drain.
- Starvation: 1 buffered entry, ALU valid every cycle, STARVE_LIMIT=4 -> 4 ALU writes, then alu_ready=0 for one cycle and the buffered rd is written, then ALU resumes.
- Order/duplicates: push rd=5 data=1 then rd=5 data=2, ALU idle -> two consecutive writes to r5 (1 then 2), busy_mask[5] clears only after the second.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: merges single-cycle ALU results with buffered long-latency results
// into one registered register-file write per cycle, and exports a pending-write mask.
module wb_stage #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [ADDR_W-1:0]    lsu_rd,
    input  logic [DATA_W-1:0]    lsu_data,
    output logic                 reg_write,
    output logic [ADDR_W-1:0]    rd,
    output logic [DATA_W-1:0]    write_data,
    output logic [2**ADDR_W-1:0] busy_mask
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam int NREG  = 2**ADDR_W;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]  SC_LIMIT  = SC_W'(STARVE_LIMIT);

    logic [ADDR_W-1:0] fifo_rd_mem   [DEPTH];
    logic [DATA_W-1:0] fifo_data_mem [DEPTH];

    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic alu_fire;
    logic push;
    logic drain;
    logic fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign lsu_ready  = (count_q != FULL_CNT);
    assign alu_ready  = (starve_q != SC_LIMIT);
    assign alu_fire   = alu_valid & alu_ready;
    assign push       = lsu_valid & lsu_ready;
    // The buffer only drains in cycles the ALU does not win.
    assign drain      = ~alu_fire & ~fifo_empty;

    always_comb begin
        vld_d       = vld_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(drain);
        starve_d    = starve_q;
        reg_write_d = alu_fire | drain;
        rd_d        = rd_q;
        wdata_d     = wdata_q;

        if (drain) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (alu_fire) begin
            rd_d    = alu_rd;
            wdata_d = alu_data;
        end else if (drain) begin
            rd_d    = fifo_rd_mem[rd_ptr_q];
            wdata_d = fifo_data_mem[rd_ptr_q];
        end

        if (drain || fifo_empty) begin
            starve_d = '0;
        end else if (alu_fire && (starve_q != SC_LIMIT)) begin
            starve_d = starve_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wdata_q     <= '0;
        end else begin
            vld_q       <= vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by vld_q/count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_q]   <= lsu_rd;
            fifo_data_mem[wr_ptr_q] <= lsu_data;
        end
    end

    logic [NREG-1:0] entry_mask [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_mask
        assign entry_mask[gi] = vld_q[gi] ? (NREG'(1) << fifo_rd_mem[gi]) : '0;
    end

    always_comb begin
        busy_mask = reg_write_q ? (NREG'(1) << rd_q) : '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_mask = busy_mask | entry_mask[i];
        end
    end

    assign reg_write  = reg_write_q;
    assign rd         = rd_q;
    assign write_data = wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected commits are queued per test and a negedge
// monitor checks every register-file write against that queue in order.
module tb_wb_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 alu_valid = 1'b0;
    logic                 alu_ready;
    logic [ADDR_W-1:0]    alu_rd = '0;
    logic [DATA_W-1:0]    alu_data = '0;
    logic                 lsu_valid = 1'b0;
    logic                 lsu_ready;
    logic [ADDR_W-1:0]    lsu_rd = '0;
    logic [DATA_W-1:0]    lsu_data = '0;
    logic                 reg_write;
    logic [ADDR_W-1:0]    rd;
    logic [DATA_W-1:0]    write_data;
    logic [2**ADDR_W-1:0] busy_mask;

    wr_t sb_q[$];
    wr_t alu_src[$];
    wr_t lsu_src[$];
    wr_t exp_w;
    int  errors = 0;
    int  checks = 0;

    wb_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .reg_write(reg_write), .rd(rd), .write_data(write_data), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (rst_n && reg_write) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", rd, write_data);
            end else begin
                exp_w = sb_q.pop_front();
                if (rd !== exp_w.rd || write_data !== exp_w.data) begin
                    errors++;
                    $display("FAIL commit: got rd=%0d data=%h, expected rd=%0d data=%h",
                             rd, write_data, exp_w.rd, exp_w.data);
                end else begin
                    $display("commit rd=%0d data=%h ok", rd, write_data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic q_alu(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        alu_src.push_back({r, d});
    endtask

    task automatic q_lsu(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        lsu_src.push_back({r, d});
    endtask

    task automatic q_exp(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        sb_q.push_back({r, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents queued sources each cycle, advancing on handshake; checks the
    // ready outputs against hand-derived per-cycle masks before each edge.
    task automatic run_stream(input int ncyc, input logic [31:0] alu_mask,
                              input logic [31:0] lsu_mask, input string tag);
        for (int c = 0; c < ncyc; c++) begin
            logic af;
            logic lf;
            alu_valid = (alu_src.size() > 0);
            if (alu_valid) begin
                alu_rd   = alu_src[0].rd;
                alu_data = alu_src[0].data;
            end
            lsu_valid = (lsu_src.size() > 0);
            if (lsu_valid) begin
                lsu_rd   = lsu_src[0].rd;
                lsu_data = lsu_src[0].data;
            end
            check($sformatf("%s alu_ready c%0d", tag, c), alu_ready, alu_mask[c]);
            check($sformatf("%s lsu_ready c%0d", tag, c), lsu_ready, lsu_mask[c]);
            af = alu_valid && alu_ready;
            lf = lsu_valid && lsu_ready;
            tick();
            if (af) void'(alu_src.pop_front());
            if (lf) void'(lsu_src.pop_front());
        end
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) tick();
        check({tag, " pending_commits"}, 64'(sb_q.size()), 64'd0);
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("reset reg_write", reg_write, 1'b0);
        check("reset rd", rd, 5'd0);
        check("reset write_data", write_data, 32'd0);
        check("reset busy_mask", busy_mask, 32'd0);
        check("reset lsu_ready", lsu_ready, 1'b1);
        check("reset alu_ready", alu_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // ALU only
        q_exp(5'd3, 32'hDEADBEEF);
        q_alu(5'd3, 32'hDEADBEEF);
        run_stream(1, 32'h1, 32'h1, "alu");
        check("alu busy_mask", busy_mask, 32'h0000_0008);
        tick();
        check("alu idle reg_write", reg_write, 1'b0);
        wait_drain("alu");

        // LSU only: buffered for one cycle, commits the next
        q_exp(5'd7, 32'h12345678);
        q_lsu(5'd7, 32'h12345678);
        run_stream(1, 32'h1, 32'h1, "lsu");
        check("lsu buffered busy_mask", busy_mask, 32'h0000_0080);
        check("lsu buffered reg_write", reg_write, 1'b0);
        tick();
        check("lsu commit reg_write", reg_write, 1'b1);
        check("lsu commit busy_mask", busy_mask, 32'h0000_0080);
        tick();
        check("lsu done busy_mask", busy_mask, 32'd0);
        wait_drain("lsu");

        // Fill/backpressure with ALU always valid; starvation releases B1 after 4 wins
        q_alu(5'd1, 32'hA1);  q_alu(5'd2, 32'hA2);  q_alu(5'd0, 32'hA3);
        q_alu(5'd4, 32'hA4);  q_alu(5'd6, 32'hA5);  q_alu(5'd8, 32'hA6);
        q_lsu(5'd10, 32'hB1); q_lsu(5'd11, 32'hB2); q_lsu(5'd12, 32'hB3);
        q_exp(5'd1, 32'hA1);  q_exp(5'd2, 32'hA2);  q_exp(5'd0, 32'hA3);
        q_exp(5'd4, 32'hA4);  q_exp(5'd6, 32'hA5);  q_exp(5'd10, 32'hB1);
        q_exp(5'd8, 32'hA6);  q_exp(5'd11, 32'hB2); q_exp(5'd12, 32'hB3);
        run_stream(10, 32'h3DF, 32'h343, "fill");
        wait_drain("fill");

        // Starvation with one entry already buffered
        q_lsu(5'd20, 32'h5020);
        run_stream(1, 32'h1, 32'h1, "starve_push");
        q_alu(5'd16, 32'hC0); q_alu(5'd17, 32'hC1); q_alu(5'd18, 32'hC2);
        q_alu(5'd19, 32'hC3); q_alu(5'd21, 32'hC4);
        q_exp(5'd16, 32'hC0); q_exp(5'd17, 32'hC1); q_exp(5'd18, 32'hC2);
        q_exp(5'd19, 32'hC3); q_exp(5'd20, 32'h5020); q_exp(5'd21, 32'hC4);
        run_stream(7, 32'h6F, 32'h7F, "starve");
        wait_drain("starve");

        // Duplicate destination, in-order commits
        q_lsu(5'd5, 32'd1); q_lsu(5'd5, 32'd2);
        q_exp(5'd5, 32'd1); q_exp(5'd5, 32'd2);
        run_stream(2, 32'h3, 32'h3, "dup");
        check("dup first busy_mask", busy_mask, 32'h0000_0020);
        tick();
        check("dup second busy_mask", busy_mask, 32'h0000_0020);
        tick();
        check("dup done busy_mask", busy_mask, 32'd0);
        wait_drain("dup");

        // Reset with two entries buffered discards them
        q_alu(5'd9, 32'h99);   q_alu(5'd13, 32'h13);
        q_lsu(5'd14, 32'h14);  q_lsu(5'd15, 32'h15);
        q_exp(5'd9, 32'h99);   q_exp(5'd13, 32'h13);
        run_stream(2, 32'h3, 32'h3, "rstmid");
        check("rstmid busy_mask", busy_mask, 32'h0000_E000);
        check("rstmid lsu_ready", lsu_ready, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid reg_write", reg_write, 1'b0);
        check("rstmid busy_mask after", busy_mask, 32'd0);
        check("rstmid lsu_ready after", lsu_ready, 1'b1);
        check("rstmid alu_ready after", alu_ready, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post-reset idle reg_write c%0d", i), reg_write, 1'b0);
        end
        check("post-reset busy_mask", busy_mask, 32'd0);
        wait_drain("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
